// File: rtl/sprite_anim_renderer_if.sv
// Pixel, sprite-control, ROM and output signals of the sprite renderer.
// The slave modport is the renderer's view; master is the driver/ROM side.
interface sprite_anim_renderer_if #(
  parameter int ADDR_W = 12,
  parameter int IDX_W  = 4
);
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              blank;
  logic              frame_sync;
  logic [9:0]        sprite_x;
  logic [9:0]        sprite_y;
  logic              flip_x;
  logic              anim_en;
  logic              anim_restart;
  logic [ADDR_W-1:0] rom_address;
  logic [IDX_W-1:0]  rom_q;
  logic [IDX_W-1:0]  pix_idx;
  logic              pix_hit;
  logic [3:0]        cur_frame;

  modport slave (
    input  DrawX, DrawY, blank, frame_sync, sprite_x, sprite_y,
    input  flip_x, anim_en, anim_restart, rom_q,
    output rom_address, pix_idx, pix_hit, cur_frame
  );

  modport master (
    output DrawX, DrawY, blank, frame_sync, sprite_x, sprite_y,
    output flip_x, anim_en, anim_restart, rom_q,
    input  rom_address, pix_idx, pix_hit, cur_frame
  );
endinterface

// File: rtl/sprite_anim_renderer.sv
// Animated, scaled, optionally mirrored sprite renderer: scan position -> ROM address,
// then a 2-cycle pipeline to a palette index and opaque-hit flag.
module sprite_anim_renderer #(
  parameter int SPR_W       = 32,
  parameter int SPR_H       = 32,
  parameter int SCALE_LOG2  = 1,
  parameter int FRAMES      = 4,
  parameter int FRAME_TICKS = 8,
  parameter int IDX_W       = 4,
  parameter logic [IDX_W-1:0] TRANSPARENT_IDX = '0
) (
  input  logic                  vga_clk,
  input  logic                  reset_n,
  sprite_anim_renderer_if.slave bus
);
  localparam int ADDR_W = $clog2(FRAMES * SPR_W * SPR_H);
  localparam int U_W    = $clog2(SPR_W);
  localparam int V_W    = $clog2(SPR_H);
  localparam logic [10:0] BOX_W      = 11'(SPR_W << SCALE_LOG2);
  localparam logic [10:0] BOX_H      = 11'(SPR_H << SCALE_LOG2);
  localparam logic [3:0]  LAST_FRAME = 4'(FRAMES - 1);
  localparam logic [7:0]  LAST_TICK  = 8'(FRAME_TICKS - 1);

  logic [9:0]       pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic             flip_q, flip_d;
  logic [3:0]       cur_frame_q, cur_frame_d;
  logic [7:0]       tick_q, tick_d;
  logic             hit_d1_q;
  logic             pix_hit_q;
  logic [IDX_W-1:0] pix_idx_q;

  logic [10:0]      lx, ly;
  logic             in_box;
  logic [U_W-1:0]   u_raw, u_idx;
  logic [V_W-1:0]   v_idx;

  // Sprite state only changes on frame_sync so a frame is never drawn half old, half new.
  always_comb begin
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    flip_d      = flip_q;
    cur_frame_d = cur_frame_q;
    tick_d      = tick_q;
    if (bus.frame_sync) begin
      pos_x_d = bus.sprite_x;
      pos_y_d = bus.sprite_y;
      flip_d  = bus.flip_x;
      if (bus.anim_restart) begin
        cur_frame_d = '0;
        tick_d      = '0;
      end else if (bus.anim_en) begin
        if (tick_q == LAST_TICK) begin
          tick_d      = '0;
          cur_frame_d = (cur_frame_q == LAST_FRAME) ? 4'd0 : cur_frame_q + 4'd1;
        end else begin
          tick_d = tick_q + 8'd1;
        end
      end
    end
  end

  // 11-bit differences: bit 10 set means the scan point is left of / above the sprite.
  assign lx     = {1'b0, bus.DrawX} - {1'b0, pos_x_q};
  assign ly     = {1'b0, bus.DrawY} - {1'b0, pos_y_q};
  assign in_box = ~lx[10] & ~ly[10] & (lx < BOX_W) & (ly < BOX_H);
  assign u_raw  = lx[SCALE_LOG2 +: U_W];
  assign v_idx  = ly[SCALE_LOG2 +: V_W];
  // SPR_W is a power of two, so SPR_W-1-u is just the bitwise complement.
  assign u_idx  = flip_q ? ~u_raw : u_raw;

  assign bus.rom_address = in_box
                         ? ((ADDR_W'(cur_frame_q) << (U_W + V_W)) | ADDR_W'({v_idx, u_idx}))
                         : '0;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      flip_q      <= 1'b0;
      cur_frame_q <= '0;
      tick_q      <= '0;
      hit_d1_q    <= 1'b0;
      pix_hit_q   <= 1'b0;
      pix_idx_q   <= TRANSPARENT_IDX;
    end else begin
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      flip_q      <= flip_d;
      cur_frame_q <= cur_frame_d;
      tick_q      <= tick_d;
      hit_d1_q    <= in_box & bus.blank;
      pix_hit_q   <= hit_d1_q & (bus.rom_q != TRANSPARENT_IDX);
      pix_idx_q   <= hit_d1_q ? bus.rom_q : TRANSPARENT_IDX;
    end
  end

  assign bus.pix_hit   = pix_hit_q;
  assign bus.pix_idx   = pix_idx_q;
  assign bus.cur_frame = cur_frame_q;
endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Self-checking bench: behavioural sprite model compared every cycle, plus directed literal checks.
module tb_sprite_anim_renderer;
  localparam int SPR_W  = 32;
  localparam int SPR_H  = 32;
  localparam int SC     = 2;
  localparam int FRAMES = 4;
  localparam int FT     = 2;
  localparam int ADDR_W = 12;

  logic vga_clk;
  logic reset_n;
  logic chk_en;
  int   n_checks;
  int   n_errors;
  logic [3:0] rom_mem [0:4095];

  sprite_anim_renderer_if #(.ADDR_W(ADDR_W), .IDX_W(4)) bus ();

  sprite_anim_renderer #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .SCALE_LOG2(1), .FRAMES(FRAMES),
    .FRAME_TICKS(FT), .IDX_W(4), .TRANSPARENT_IDX(4'd0)
  ) dut (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // Synchronous ROM with one cycle of read latency.
  always @(posedge vga_clk) bus.rom_q <= rom_mem[bus.rom_address];

  // Reference model: latched position/flip and a count of enabled pulses since restart.
  int   m_px, m_py, m_cnt;
  bit   m_flip;
  bit   p1_hit, p2_hit;
  int   p1_val, p2_idx;

  function automatic bit m_in(int dx, int dy, int px, int py);
    int lx = dx - px;
    int ly = dy - py;
    return (lx >= 0) && (ly >= 0) && (lx < SPR_W * SC) && (ly < SPR_H * SC);
  endfunction

  function automatic int m_frame(int cnt);
    return (cnt / FT) % FRAMES;
  endfunction

  function automatic int m_addr(int dx, int dy, int px, int py, bit fl, int fr);
    int u, v;
    if (!m_in(dx, dy, px, py)) return 0;
    u = (dx - px) / SC;
    v = (dy - py) / SC;
    if (fl) u = SPR_W - 1 - u;
    return fr * SPR_W * SPR_H + v * SPR_W + u;
  endfunction

  always @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      m_px <= 0; m_py <= 0; m_flip <= 1'b0; m_cnt <= 0;
      p1_hit <= 1'b0; p1_val <= 0; p2_hit <= 1'b0; p2_idx <= 0;
    end else begin
      p1_hit <= m_in(int'(bus.DrawX), int'(bus.DrawY), m_px, m_py) && bus.blank;
      p1_val <= int'(rom_mem[m_addr(int'(bus.DrawX), int'(bus.DrawY), m_px, m_py, m_flip,
                                    m_frame(m_cnt))]);
      p2_hit <= p1_hit && (p1_val != 0);
      p2_idx <= p1_hit ? p1_val : 0;
      if (bus.frame_sync) begin
        m_px   <= int'(bus.sprite_x);
        m_py   <= int'(bus.sprite_y);
        m_flip <= bus.flip_x;
        if (bus.anim_restart) m_cnt <= 0;
        else if (bus.anim_en) m_cnt <= m_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge vga_clk) begin
    if (chk_en) begin
      chk("model_pix_hit", 32'(bus.pix_hit), 32'(p2_hit));
      chk("model_pix_idx", 32'(bus.pix_idx), 32'(p2_idx));
      chk("model_cur_frame", 32'(bus.cur_frame), 32'(m_frame(m_cnt)));
      chk("model_rom_address", 32'(bus.rom_address),
          32'(m_addr(int'(bus.DrawX), int'(bus.DrawY), m_px, m_py, m_flip, m_frame(m_cnt))));
    end
  end

  task automatic cyc();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic pulse();
    bus.frame_sync = 1'b1;
    cyc();
    bus.frame_sync = 1'b0;
    cyc();
  endtask

  task automatic set_pix(input int x, input int y, input bit b);
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    bus.blank = b;
  endtask

  int anim_exp [9] = '{0, 1, 1, 2, 2, 3, 3, 0, 0};
  int tgt_x, tgt_y, dx, dy;

  initial begin
    n_checks = 0; n_errors = 0; chk_en = 1'b0;
    for (int i = 0; i < 4096; i++) rom_mem[i] = 4'(15 - (i % 16));
    reset_n = 1'b1;
    set_pix(0, 0, 1'b1);
    bus.frame_sync = 1'b0; bus.sprite_x = '0; bus.sprite_y = '0;
    bus.flip_x = 1'b0; bus.anim_en = 1'b0; bus.anim_restart = 1'b0;
    #1 reset_n = 1'b0;
    #1 chk_en = 1'b1;

    // Reset holds outputs regardless of clocking
    repeat (3) begin
      cyc();
      chk("reset_pix_hit", 32'(bus.pix_hit), 0);
      chk("reset_pix_idx", 32'(bus.pix_idx), 0);
      chk("reset_cur_frame", 32'(bus.cur_frame), 0);
    end
    reset_n = 1'b1;
    cyc();
    chk("post_reset_edge1_hit", 32'(bus.pix_hit), 0);
    cyc();
    chk("post_reset_edge2_hit", 32'(bus.pix_hit), 1);

    // Placement and latency at (100,50)
    bus.sprite_x = 10'd100; bus.sprite_y = 10'd50;
    pulse();
    set_pix(99, 50, 1'b1); #1 chk("addr_x99", 32'(bus.rom_address), 0);
    cyc();
    set_pix(100, 50, 1'b1); #1 chk("addr_origin", 32'(bus.rom_address), 0);
    cyc();
    chk("hit_x99", 32'(bus.pix_hit), 0);
    set_pix(163, 50, 1'b1); #1 chk("addr_x163_u31", 32'(bus.rom_address), 31);
    cyc();
    chk("hit_x100", 32'(bus.pix_hit), 1);
    chk("idx_x100", 32'(bus.pix_idx), 15);
    set_pix(164, 50, 1'b1); #1 chk("addr_x164", 32'(bus.rom_address), 0);
    cyc();
    chk("hit_x163_transparent", 32'(bus.pix_hit), 0);
    set_pix(0, 0, 1'b0);
    cyc();
    chk("hit_x164", 32'(bus.pix_hit), 0);

    // Scaling with flip
    bus.flip_x = 1'b1;
    pulse();
    set_pix(102, 53, 1'b1); #1 chk("addr_flip_scale", 32'(bus.rom_address), 62);
    cyc();
    set_pix(0, 0, 1'b0);
    cyc();
    chk("hit_flip_scale", 32'(bus.pix_hit), 1);
    chk("idx_flip_scale", 32'(bus.pix_idx), 1);
    bus.flip_x = 1'b0;

    // Animation stepping and wrap
    bus.anim_restart = 1'b1; pulse(); bus.anim_restart = 1'b0;
    bus.anim_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      pulse();
      chk($sformatf("anim_pulse%0d", i + 1), 32'(bus.cur_frame), 32'(anim_exp[i]));
    end
    pulse(); chk("anim_pulse10", 32'(bus.cur_frame), 1);
    bus.anim_restart = 1'b1; pulse(); bus.anim_restart = 1'b0;
    chk("anim_restart", 32'(bus.cur_frame), 0);
    pulse(); chk("anim_after_restart1", 32'(bus.cur_frame), 0);
    pulse(); chk("anim_after_restart2", 32'(bus.cur_frame), 1);
    bus.anim_en = 1'b0;

    // Transparency and blanking
    pulse();
    set_pix(130, 50, 1'b1); cyc(); set_pix(0, 0, 1'b0); cyc();
    chk("transparent_hit", 32'(bus.pix_hit), 0);
    chk("transparent_idx", 32'(bus.pix_idx), 0);
    set_pix(120, 50, 1'b0); cyc(); set_pix(0, 0, 1'b0); cyc();
    chk("blank_hit", 32'(bus.pix_hit), 0);
    chk("blank_idx", 32'(bus.pix_idx), 0);
    set_pix(120, 50, 1'b1); cyc(); set_pix(0, 0, 1'b0); cyc();
    chk("opaque_hit", 32'(bus.pix_hit), 1);
    chk("opaque_idx", 32'(bus.pix_idx), 5);

    // No tearing: new position only after frame_sync
    set_pix(110, 60, 1'b1); #1 chk("tear_addr_before", 32'(bus.rom_address), 1189);
    bus.sprite_x = 10'd200; #1 chk("tear_addr_moved", 32'(bus.rom_address), 1189);
    cyc();
    bus.frame_sync = 1'b1; #1 chk("tear_addr_sync_cycle", 32'(bus.rom_address), 1189);
    cyc();
    bus.frame_sync = 1'b0; #1 chk("tear_addr_old_x", 32'(bus.rom_address), 0);
    set_pix(210, 60, 1'b1); #1 chk("tear_addr_new_x", 32'(bus.rom_address), 1189);
    cyc();

    // Randomised traffic against the model
    for (int i = 0; i < 4096; i++) rom_mem[i] = 4'($urandom_range(0, 15));
    tgt_x = 200; tgt_y = 100;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 59) == 0) begin
        tgt_x = ($urandom_range(0, 9) == 0) ? int'($urandom_range(960, 1023)) : int'($urandom_range(0, 700));
        tgt_y = ($urandom_range(0, 9) == 0) ? int'($urandom_range(960, 1023)) : int'($urandom_range(0, 500));
      end
      bus.sprite_x     = 10'(tgt_x);
      bus.sprite_y     = 10'(tgt_y);
      bus.flip_x       = 1'($urandom_range(0, 1));
      bus.anim_en      = ($urandom_range(0, 3) != 0);
      bus.anim_restart = ($urandom_range(0, 7) == 0);
      bus.frame_sync   = ($urandom_range(0, 29) == 0);
      dx = m_px + int'($urandom_range(0, 80)) - 8;
      dy = m_py + int'($urandom_range(0, 80)) - 8;
      set_pix(dx & 1023, dy & 1023, ($urandom_range(0, 7) != 0));
      if ($urandom_range(0, 599) == 0) begin
        #2 reset_n = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b1;
      end else begin
        cyc();
      end
    end

    bus.frame_sync = 1'b0;
    cyc();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
